// File: rtl/div_pkg.sv
// Shared types and constants for the sequential restoring divider.
package div_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEF_DW      = 16;
  localparam int DEF_VW      = 8;
  localparam int APPROX_BITS = 4;

  // Wide enough for any practical DW; the top slices the low DW bits.
  localparam logic [63:0] ZDIV_QUOT = '1;

endpackage

// File: rtl/div_step.sv
// One restoring-division iteration: shift in a dividend bit, conditionally subtract.
module div_step #(
  parameter int VW = 8
) (
  input  logic [VW-1:0] rem_i,
  input  logic          bit_i,
  input  logic [VW-1:0] div_i,
  output logic [VW-1:0] rem_o,
  output logic          q_o
);

  logic [VW:0] shifted;

  assign shifted = {rem_i, bit_i};
  assign q_o     = (shifted >= {1'b0, div_i});
  // The true difference is below div_i, so the low VW bits of a VW-bit subtract are exact.
  assign rem_o   = q_o ? (shifted[VW-1:0] - div_i) : shifted[VW-1:0];

endmodule

// File: rtl/div_16_8_seq.sv
// Sequential unsigned divider, one restoring step per cycle.
// Define DIV_APPROX_EN to stop after DW-4 steps (low quotient bits and remainder forced to zero).
module div_16_8_seq
  import div_pkg::*;
#(
  parameter int DW = DEF_DW,
  parameter int VW = DEF_VW
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [DW-1:0] dividend,
  input  logic [VW-1:0] divisor,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [DW-1:0] quotient,
  output logic [VW-1:0] remainder,
  output logic          div_by_zero
);

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high;
  // out_valid is never withdrawn and the result holds until out_ready accepts it.

  localparam int CNT_W = $clog2(DW);
`ifdef DIV_APPROX_EN
  localparam int LAST_CNT = APPROX_BITS;
`else
  localparam int LAST_CNT = 0;
`endif

  state_t             state_q;
  logic [DW-1:0]      work_q;
  logic [VW-1:0]      div_q;
  logic [VW-1:0]      rem_q;
  logic [CNT_W-1:0]   cnt_q;
  logic [DW-1:0]      quot_q;
  logic [VW-1:0]      remd_q;
  logic               dbz_q;
  logic               ov_q;

  logic [DW-1:0]      work_d;
  logic [VW-1:0]      rem_d;
  logic               q_bit;
  logic               last_iter;
  logic [DW-1:0]      calc_quot;
  logic [VW-1:0]      calc_rem;

  div_step #(.VW(VW)) u_step (
    .rem_i (rem_q),
    .bit_i (work_q[DW-1]),
    .div_i (div_q),
    .rem_o (rem_d),
    .q_o   (q_bit)
  );

  // work_q starts as the dividend and fills with quotient bits from the LSB side.
  assign work_d    = {work_q[DW-2:0], q_bit};
  assign last_iter = (cnt_q == CNT_W'(LAST_CNT));

`ifdef DIV_APPROX_EN
  assign calc_quot = {work_d[DW-APPROX_BITS-1:0], {APPROX_BITS{1'b0}}};
  assign calc_rem  = '0;
`else
  assign calc_quot = work_d;
  assign calc_rem  = rem_d;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      work_q  <= '0;
      div_q   <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      quot_q  <= '0;
      remd_q  <= '0;
      dbz_q   <= 1'b0;
      ov_q    <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          if (in_valid) begin
            work_q <= dividend;
            div_q  <= divisor;
            rem_q  <= '0;
            if (divisor == '0) begin
              quot_q  <= ZDIV_QUOT[DW-1:0];
              remd_q  <= dividend[VW-1:0];
              dbz_q   <= 1'b1;
              state_q <= DONE;
            end else begin
              cnt_q   <= CNT_W'(DW-1);
              state_q <= CALC;
            end
          end
        end
        CALC: begin
          work_q <= work_d;
          rem_q  <= rem_d;
          if (last_iter) begin
            quot_q  <= calc_quot;
            remd_q  <= calc_rem;
            dbz_q   <= 1'b0;
            ov_q    <= 1'b1;
            state_q <= DONE;
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        DONE: begin
          // Zero-divisor results enter DONE unpresented and raise out_valid one cycle later.
          if (!ov_q) begin
            ov_q <= 1'b1;
          end else if (out_ready) begin
            ov_q    <= 1'b0;
            state_q <= IDLE;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready    = (state_q == IDLE);
  assign out_valid   = ov_q;
  assign quotient    = quot_q;
  assign remainder   = remd_q;
  assign div_by_zero = dbz_q;

endmodule
